// File: rtl/sms_poll_sched_pkg.sv
// sms_poll_sched_pkg
//   Shared definitions for the SMS poll scheduler: FSM state encoding and
//   the send_state status codes reported by the SMS flow block.
package sms_poll_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_POLL = 3'd1,
    KICK      = 3'd2,
    RUN       = 3'd3,
    FETCH     = 3'd4,
    PUSH      = 3'd5
  } state_t;

  // send_state codes from the SMS block; any other value means "still busy"
  localparam logic [2:0] SEND_MSG_RDY = 3'd5;
  localparam logic [2:0] SEND_NO_MSG  = 3'd6;

endpackage

// File: rtl/sms_wdog_timer.sv
// sms_wdog_timer
//   Up-counter with synchronous clear and terminal-count flag. Counts while
//   run=1 and stops (no wrap) at CYCLES-1. Used both as the poll-interval
//   timer and as the modem-exchange watchdog.
// Ports
//   clk    in  1  system clock
//   rst    in  1  synchronous reset, active-low
//   clear  in  1  force count to 0 (wins over run)
//   run    in  1  advance count by one this cycle
//   tc     out 1  count has reached CYCLES-1
module sms_wdog_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tc
);

  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/sms_poll_sched.sv
// sms_poll_sched
//   Sequencer above the SMS flow block. Periodically kicks an SMS read cycle,
//   watchdogs the modem exchange with timeout + bounded retry, and on
//   message-ready walks bus_mux across the fields, streaming each dataout
//   word downstream over valid/ready.
// Ports
//   clk, rst      clock, synchronous active-low reset
//   poll_en       periodic polling enable
//   kick          1-cycle "poll now" request (honoured only in WAIT_POLL)
//   en            SMS block tx activity; restarts the watchdog
//   send_state    SMS block status (5 msg ready, 6 no msg, else busy)
//   data_en       dataout valid for the current bus_mux
//   dataout       SMS block field word
//   start, tout   1-cycle pulses to the SMS block
//   bus_mux       field select to the SMS block
//   out_valid/out_ready/out_data/out_field/out_last  downstream stream
//   busy          not in IDLE/WAIT_POLL
//   err           1-cycle pulse: retries exhausted
module sms_poll_sched
  import sms_poll_sched_pkg::*;
#(
  parameter int POLL_CYCLES = 50_000_000,
  parameter int TOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int NFIELDS     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_en,
  input  logic        kick,
  input  logic        en,
  input  logic [2:0]  send_state,
  input  logic        data_en,
  input  logic [15:0] dataout,
  output logic        start,
  output logic        tout,
  output logic [2:0]  bus_mux,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_field,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] RETRY_LAST = 3'(MAX_RETRY - 1);
  localparam logic [2:0] FIELD_LAST = 3'(NFIELDS - 1);

  state_t      state_reg, state_next, done_state;
  logic [2:0]  retry_reg, field_reg, ofield_reg;
  logic [15:0] data_reg;
  logic        last_reg, err_reg;
  logic        timeout, exhausted, msg_done;
  logic        poll_tc, wd_tc, wd_active, wd_clear;

  // Poll timer runs only in WAIT_POLL and restarts from 0 on every entry.
  sms_wdog_timer #(.CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_reg != WAIT_POLL),
    .run   (1'b1),
    .tc    (poll_tc)
  );

  // Watchdog advances only while waiting on the modem (RUN/FETCH); it is
  // frozen in PUSH so downstream backpressure never looks like a modem fault.
  assign wd_active = (state_reg == RUN) || (state_reg == FETCH);
  assign wd_clear  = (state_reg == KICK) || (wd_active && en);

  sms_wdog_timer #(.CYCLES(TOUT_CYCLES)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .run   (wd_active),
    .tc    (wd_tc)
  );

  // A finished or abandoned cycle drops straight to IDLE if polling was
  // disabled meanwhile.
  assign done_state = poll_en ? WAIT_POLL : IDLE;
  assign exhausted  = (retry_reg == RETRY_LAST);
  assign msg_done   = ((state_reg == RUN) && (send_state == SEND_NO_MSG)) ||
                      ((state_reg == PUSH) && out_ready && last_reg);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; status/data decode is checked before the watchdog so
  // it wins in the same cycle. Activity on en in the terminal cycle also
  // counts as a restart rather than a timeout.
  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (poll_en) state_next = WAIT_POLL;
      end
      WAIT_POLL: begin
        if (!poll_en)            state_next = IDLE;
        else if (poll_tc || kick) state_next = KICK;
      end
      KICK: begin
        state_next = RUN;
      end
      RUN: begin
        if (send_state == SEND_MSG_RDY)     state_next = FETCH;
        else if (send_state == SEND_NO_MSG) state_next = done_state;
        else if (wd_tc && !en)              timeout    = 1'b1;
      end
      FETCH: begin
        if (data_en)            state_next = PUSH;
        else if (wd_tc && !en)  timeout    = 1'b1;
      end
      PUSH: begin
        if (out_ready) state_next = last_reg ? done_state : FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (timeout) state_next = exhausted ? done_state : KICK;
  end

  // Datapath registers: retry count, field pointer, captured word, err pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      retry_reg  <= '0;
      field_reg  <= '0;
      ofield_reg <= '0;
      data_reg   <= '0;
      last_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= timeout && exhausted;

      if (timeout)       retry_reg <= exhausted ? 3'd0 : retry_reg + 3'd1;
      else if (msg_done) retry_reg <= '0;

      // field_reg drives bus_mux directly and holds outside FETCH/PUSH
      if ((state_reg == RUN) && (send_state == SEND_MSG_RDY))
        field_reg <= '0;
      else if ((state_reg == PUSH) && out_ready && !last_reg)
        field_reg <= field_reg + 3'd1;

      if ((state_reg == FETCH) && data_en) begin
        data_reg   <= dataout;
        ofield_reg <= field_reg;
        last_reg   <= (field_reg == FIELD_LAST);
      end
    end
  end

  // Outputs
  always_comb begin
    start     = (state_reg == KICK);
    out_valid = (state_reg == PUSH);
    busy      = (state_reg != IDLE) && (state_reg != WAIT_POLL);
    tout      = timeout;
  end

  assign bus_mux   = field_reg;
  assign out_data  = data_reg;
  assign out_field = ofield_reg;
  assign out_last  = last_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sms_poll_sched.sv
// tb_sms_poll_sched
//   Self-checking bench for sms_poll_sched with a small behavioural model of
//   the SMS flow block. Expected stream words are queued when a message is
//   requested and compared as the DUT hands them over.
module tb_sms_poll_sched;

  localparam int POLL = 20;
  localparam int TOUT = 8;
  localparam int MAXR = 3;
  localparam int NF   = 5;

  logic        clk = 1'b0;
  logic        rst, poll_en, kick, en, data_en, out_ready;
  logic [2:0]  send_state;
  logic [15:0] dataout;
  logic        start, tout, out_valid, out_last, busy, err;
  logic [2:0]  bus_mux, out_field;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;
  // SMS model behaviour: 0 silent, 1 no message, 2 message, 3 en toggling
  int mode  = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  field;
    logic        last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sms_poll_sched #(
    .POLL_CYCLES (POLL),
    .TOUT_CYCLES (TOUT),
    .MAX_RETRY   (MAXR),
    .NFIELDS     (NF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .poll_en    (poll_en),
    .kick       (kick),
    .en         (en),
    .send_state (send_state),
    .data_en    (data_en),
    .dataout    (dataout),
    .start      (start),
    .tout       (tout),
    .bus_mux    (bus_mux),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_field  (out_field),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  // SMS flow block model: answers 3 cycles after start, serves fields on demand
  initial begin
    int since;
    int tog;
    since = 100; tog = 0;
    send_state = 3'd0; data_en = 1'b0; dataout = 16'h0; en = 1'b0;
    forever begin
      @(negedge clk);
      if (start) begin
        since = 0;
        send_state = 3'd0;
      end else if (since < 100) begin
        since++;
      end
      tog = (tog + 1) % 10;
      if (since == 3 && mode == 1) send_state = 3'd6;
      if (since == 3 && mode == 2) send_state = 3'd5;
      data_en = (mode == 2) && (since >= 3);
      en      = data_en || ((mode == 3) && (tog < 5));
      dataout = 16'hA000 + {13'd0, bus_mux};
    end
  end

  task automatic test_reset;
    logic [31:0] obs;
    rst = 1'b0; poll_en = 1'b0; kick = 1'b0; out_ready = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    obs = {start, tout, bus_mux, out_valid, out_data, out_field, out_last, busy, err};
    total++;
    if (obs !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end else begin
      $display("reset: all outputs 0");
    end
    rst = 1'b1;
  endtask

  task automatic test_poll_nomsg;
    int t_prev, n;
    bit seen_valid;
    mode = 1; poll_en = 1'b1; n = 0; t_prev = -1; seen_valid = 1'b0;
    for (int cyc = 0; cyc < 120 && n < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
      if (start) begin
        if (t_prev >= 0) begin
          total++;
          if (cyc - t_prev != POLL + 4) begin
            bad++;
            $display("FAIL poll_period got=%0d want=%0d", cyc - t_prev, POLL + 4);
          end else begin
            $display("poll: start period=%0d", cyc - t_prev);
          end
        end
        t_prev = cyc;
        n++;
      end
    end
    total++;
    if (n < 4) begin
      bad++;
      $display("FAIL poll_starts got=%0d want=4", n);
    end
    total++;
    if (seen_valid) begin
      bad++;
      $display("FAIL poll_no_valid got=1 want=0");
    end
  endtask

  task automatic test_fetch;
    exp_t e;
    bit saw_tout;
    mode = 2; out_ready = 1'b1; saw_tout = 1'b0;
    for (int f = 0; f < NF; f++) begin
      e.data = 16'hA000 + 16'(f); e.field = 3'(f); e.last = (f == NF - 1);
      sb.push_back(e);
    end
    for (int cyc = 0; cyc < 150 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      if (tout) saw_tout = 1'b1;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_data !== e.data || out_field !== e.field || out_last !== e.last || bus_mux !== e.field) begin
          bad++;
          $display("FAIL fetch_word got=%h/%0d/%b mux=%0d want=%h/%0d/%b",
                   out_data, out_field, out_last, bus_mux, e.data, e.field, e.last);
        end else begin
          $display("fetch: word=%h field=%0d last=%b", out_data, out_field, out_last);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL fetch_complete got=%0d left want=0", sb.size());
    end
    sb.delete();
    total++;
    if (saw_tout) begin
      bad++;
      $display("FAIL fetch_no_tout got=1 want=0");
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    bit stalled;
    mode = 2; out_ready = 1'b1; stalled = 1'b0;
    for (int f = 0; f < NF; f++) begin
      e.data = 16'hA000 + 16'(f); e.field = 3'(f); e.last = (f == NF - 1);
      sb.push_back(e);
    end
    for (int cyc = 0; cyc < 200 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      // FETCH of field 2: refuse the word for 10 cycles once it is offered
      if (!stalled && busy && !out_valid && bus_mux == 3'd2) begin
        out_ready = 1'b0; stalled = 1'b1;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1 || out_data !== 16'hA002 || bus_mux !== 3'd2 || tout !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got v=%b d=%h mux=%0d tout=%b want v=1 d=a002 mux=2 tout=0",
                     s, out_valid, out_data, bus_mux, tout);
          end
        end
        $display("stall: word a002 held for 10 cycles");
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_data !== e.data || out_field !== e.field || out_last !== e.last) begin
          bad++;
          $display("FAIL bp_word got=%h/%0d/%b want=%h/%0d/%b",
                   out_data, out_field, out_last, e.data, e.field, e.last);
        end else begin
          $display("bp: word=%h field=%0d last=%b", out_data, out_field, out_last);
        end
      end
    end
    total++;
    if (sb.size() != 0 || !stalled) begin
      bad++;
      $display("FAIL bp_complete got=%0d left stalled=%b want=0 left stalled=1", sb.size(), stalled);
    end
    sb.delete();
  endtask

  task automatic test_timeout;
    int tout_t[$];
    int start_t[$];
    int err_t;
    bit ok, busy_at_err;
    mode = 0; out_ready = 1'b1; ok = 1'b0; err_t = -1; busy_at_err = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL tout_first_start got=none want=start");
    end
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (tout)  tout_t.push_back(i);
      if (start) start_t.push_back(i);
      if (err) begin err_t = i; busy_at_err = busy; end
    end
    total++;
    if (tout_t.size() != 3 || tout_t[0] != TOUT || tout_t[1] != 2 * TOUT + 1 || tout_t[2] != 3 * TOUT + 2) begin
      bad++;
      $display("FAIL tout_times got n=%0d want n=3 at %0d,%0d,%0d", tout_t.size(), TOUT, 2 * TOUT + 1, 3 * TOUT + 2);
    end else begin
      $display("tout: pulses at %0d,%0d,%0d", tout_t[0], tout_t[1], tout_t[2]);
    end
    total++;
    if (start_t.size() != 2 || start_t[0] != TOUT + 1 || start_t[1] != 2 * TOUT + 2) begin
      bad++;
      $display("FAIL retry_starts got n=%0d want n=2 at %0d,%0d", start_t.size(), TOUT + 1, 2 * TOUT + 2);
    end
    total++;
    if (err_t != 3 * TOUT + 3 || busy_at_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse got t=%0d busy=%b want t=%0d busy=0", err_t, busy_at_err, 3 * TOUT + 3);
    end else begin
      $display("err: pulse at %0d, back to wait", err_t);
    end
  endtask

  task automatic test_en_toggle;
    int n_tout, n_start, n_idle;
    bit ok;
    mode = 3; ok = 1'b0; n_tout = 0; n_start = 0; n_idle = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tout)  n_tout++;
      if (start) n_start++;
      if (!busy) n_idle++;
    end
    total++;
    if (!ok || n_tout != 0 || n_start != 0 || n_idle != 0) begin
      bad++;
      $display("FAIL en_alive got start=%b tout=%0d restart=%0d idle=%0d want 1/0/0/0", ok, n_tout, n_start, n_idle);
    end else begin
      $display("en_toggle: 100 cycles in RUN, no tout");
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] obs;
    bit kicked, done;
    int n_start;
    mode = 2; out_ready = 1'b1; kick = 1'b0; poll_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL kick_wait_poll got start=%b want 1", start);
    end
    kicked = 1'b0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!kicked && busy && !out_valid && bus_mux == 3'd1) begin
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0; kicked = 1'b1;
        total++;
        if (start !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL kick_in_fetch got start=%b busy=%b want 0/1", start, busy);
        end
      end else if (busy && !out_valid && bus_mux == 3'd3) begin
        rst = 1'b0;
        @(negedge clk);
        obs = {start, tout, bus_mux, out_valid, out_data, out_field, out_last, busy, err};
        total++;
        if (obs !== 32'h0) begin
          bad++;
          $display("FAIL reset_mid_fetch got=%h want=0", obs);
        end else begin
          $display("reset_mid: outputs cleared during field 3");
        end
        rst = 1'b1; poll_en = 1'b0; done = 1'b1;
        break;
      end
    end
    total++;
    if (!done || !kicked) begin
      bad++;
      $display("FAIL reset_mid_reach got done=%b kicked=%b want 1/1", done, kicked);
    end
    n_start = 0;
    for (int i = 0; i < 2 * POLL; i++) begin
      @(negedge clk);
      if (start || busy) n_start++;
    end
    total++;
    if (n_start != 0) begin
      bad++;
      $display("FAIL poll_disabled got=%0d active cycles want=0", n_start);
    end
  endtask

  initial begin
    test_reset();
    test_poll_nomsg();
    test_fetch();
    test_backpressure();
    test_timeout();
    test_en_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
